// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the Ripple-32 multi-cycle control unit.
package ripple_ctrl_pkg;

   // Controller states, in the order a typical instruction walks through them.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   // RV32I major opcodes.
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ALU operation codes driven on alu_op.
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   // Immediate formats.
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // Writeback source select.
   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd2;

   // ALU operand selects.
   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;
   localparam logic       SRC_B_RS2  = 1'b0;
   localparam logic       SRC_B_IMM  = 1'b1;

   // Trap causes reported on trap_cause.
   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_ECALL   = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   // One-hot instruction class, registered by the FSM in DECODE.
   typedef struct packed {
      logic is_alu_reg;
      logic is_alu_imm;
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_jal;
      logic is_jalr;
      logic is_lui;
      logic is_auipc;
      logic is_system;
   } instr_class_t;

   // funct7b5 picks SUB only for register ADD; on funct3=101 it picks SRA
   // for both register and immediate shifts.
   function automatic logic [3:0] alu_decode(input logic [2:0] funct3,
                                             input logic       funct7b5,
                                             input logic       is_alu_reg);
      logic [3:0] op;
      op = ALU_ADD;
      case (funct3)
         3'b000:  op = (is_alu_reg && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Shared memory port handshake between the control unit and memory.
interface multicycle_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic addr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output addr_src, input mem_ready);
   modport slave  (input mem_req, input mem_we, input addr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_opcode_decoder.sv
// Combinational opcode classifier; also flags malformed shift-immediates.
import ripple_ctrl_pkg::*;

module opcode_decoder (
   input  logic [6:0]   opcode_i,
   input  logic [2:0]   funct3_i,
   input  logic [6:0]   funct7_i,
   output instr_class_t cls_o,
   output logic         illegal_o
);

   // Opcode to one-hot class; unknown opcodes and bad shift-immediate funct7 are illegal.
   always_comb begin
      cls_o     = '0;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OPC_OP:     cls_o.is_alu_reg = 1'b1;
         OPC_OP_IMM: cls_o.is_alu_imm = 1'b1;
         OPC_LOAD:   cls_o.is_load    = 1'b1;
         OPC_STORE:  cls_o.is_store   = 1'b1;
         OPC_BRANCH: cls_o.is_branch  = 1'b1;
         OPC_JAL:    cls_o.is_jal     = 1'b1;
         OPC_JALR:   cls_o.is_jalr    = 1'b1;
         OPC_LUI:    cls_o.is_lui     = 1'b1;
         OPC_AUIPC:  cls_o.is_auipc   = 1'b1;
         OPC_SYSTEM: cls_o.is_system  = 1'b1;
         default:    illegal_o        = 1'b1;
      endcase
      // SLLI/SRLI/SRAI share funct3[1:0]=01; only funct7 0x00 or 0x20 is a valid shift.
      if (cls_o.is_alu_imm && (funct3_i[1:0] == 2'b01) &&
          (funct7_i != 7'h00) && (funct7_i != 7'h20)) begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the Ripple-32 RV32I core.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | request instruction at PC; on ready latch IR and PC+4
// S_DECODE | classify opcode, register class/funct3/funct7b5, trap if bad
// S_EXEC   | drive ALU for the class; branches/jumps update PC here
// S_MEM    | load/store request at the ALU address
// S_WB     | one-cycle register file write
// S_TRAP   | sticky halt until reset; all enables low
import ripple_ctrl_pkg::*;

module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT    = 16,
   parameter bit SUPPORT_SYSTEM = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   multicycle_control_fsm_if.master        mem,
   input  logic [31:0]                     instr_i,
   input  logic                            branch_taken_i,
   output logic                            ir_write_o,
   output logic                            pc_write_o,
   output logic                            pc_src_o,
   output logic                            reg_write_o,
   output logic [1:0]                      result_src_o,
   output logic [1:0]                      alu_src_a_o,
   output logic                            alu_src_b_o,
   output logic [2:0]                      imm_src_o,
   output logic [3:0]                      alu_op_o,
   output logic                            halted_o,
   output logic [1:0]                      trap_cause_o
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
   // Trap is decided at the edge that would bring the count up to MEM_TIMEOUT.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [1:0]        cause_q, cause_d;
   instr_class_t      cls_q, cls_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              f7b5_q, f7b5_d;

   instr_class_t      dec_cls;
   logic              dec_illegal;
   logic              timeout_hit;

   logic              mem_req, mem_we, addr_src;
   logic              ir_write, pc_write, pc_src, reg_write;
   logic [1:0]        result_src, alu_src_a;
   logic              alu_src_b;
   logic [2:0]        imm_src;
   logic [3:0]        alu_op;

   logic [1:0]        ex_src_a;
   logic              ex_src_b;
   logic [2:0]        ex_imm;
   logic [3:0]        ex_op;

   logic              unused_instr;
   assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

   opcode_decoder u_dec (
      .opcode_i  (instr_i[6:0]),
      .funct3_i  (instr_i[14:12]),
      .funct7_i  (instr_i[31:25]),
      .cls_o     (dec_cls),
      .illegal_o (dec_illegal)
   );

   assign timeout_hit = TIMEOUT_EN && !mem.mem_ready && (wait_q == WAIT_LAST);

   // ALU operand/operation selects for the registered instruction class.
   always_comb begin
      ex_src_a = SRC_A_RS1;
      ex_src_b = SRC_B_RS2;
      ex_imm   = IMM_I;
      ex_op    = ALU_ADD;
      if (cls_q.is_alu_reg) begin
         ex_op = alu_decode(funct3_q, f7b5_q, 1'b1);
      end else if (cls_q.is_alu_imm) begin
         ex_src_b = SRC_B_IMM;
         ex_op    = alu_decode(funct3_q, f7b5_q, 1'b0);
      end else if (cls_q.is_lui) begin
         ex_src_a = SRC_A_ZERO;
         ex_src_b = SRC_B_IMM;
         ex_imm   = IMM_U;
      end else if (cls_q.is_auipc) begin
         ex_src_a = SRC_A_PC;
         ex_src_b = SRC_B_IMM;
         ex_imm   = IMM_U;
      end else if (cls_q.is_load) begin
         ex_src_b = SRC_B_IMM;
      end else if (cls_q.is_store) begin
         ex_src_b = SRC_B_IMM;
         ex_imm   = IMM_S;
      end else if (cls_q.is_branch) begin
         ex_src_a = SRC_A_PC;
         ex_src_b = SRC_B_IMM;
         ex_imm   = IMM_B;
      end else if (cls_q.is_jal) begin
         ex_src_a = SRC_A_PC;
         ex_src_b = SRC_B_IMM;
         ex_imm   = IMM_J;
      end else if (cls_q.is_jalr) begin
         ex_src_b = SRC_B_IMM;
      end
   end

   // Next-state, wait counter, trap cause and control output decode.
   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      cause_d    = cause_q;
      cls_d      = cls_q;
      funct3_d   = funct3_q;
      f7b5_d     = f7b5_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALU;
      alu_src_a  = SRC_A_RS1;
      alu_src_b  = SRC_B_RS2;
      imm_src    = IMM_I;
      alu_op     = ALU_ADD;

      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout_hit) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            cls_d    = dec_cls;
            funct3_d = instr_i[14:12];
            f7b5_d   = instr_i[30];
            if (dec_illegal) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end else if (dec_cls.is_system) begin
               cause_d = SUPPORT_SYSTEM ? CAUSE_ECALL : CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_src_a = ex_src_a;
            alu_src_b = ex_src_b;
            imm_src   = ex_imm;
            alu_op    = ex_op;
            if (cls_q.is_branch) begin
               pc_src   = 1'b1;
               pc_write = branch_taken_i;
               state_d  = S_FETCH;
            end else if (cls_q.is_jal || cls_q.is_jalr) begin
               pc_src   = 1'b1;
               pc_write = 1'b1;
               state_d  = S_WB;
            end else if (cls_q.is_load || cls_q.is_store) begin
               state_d = S_MEM;
            end else if (cls_q.is_alu_reg || cls_q.is_alu_imm ||
                         cls_q.is_lui || cls_q.is_auipc) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = cls_q.is_store;
            addr_src  = 1'b1;
            alu_src_a = ex_src_a;
            alu_src_b = ex_src_b;
            imm_src   = ex_imm;
            alu_op    = ex_op;
            if (mem.mem_ready) begin
               state_d = cls_q.is_store ? S_FETCH : S_WB;
            end else if (timeout_hit) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            if (cls_q.is_load) begin
               result_src = RES_MEM;
            end else if (cls_q.is_jal || cls_q.is_jalr) begin
               result_src = RES_PC4;
            end
            state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Reset parks the state in FETCH; keep the fetch request quiet until release.
      if (!rst_n) begin
         mem_req  = 1'b0;
         ir_write = 1'b0;
         pc_write = 1'b0;
      end
   end

   // State, class and trap bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         wait_q   <= '0;
         cause_q  <= CAUSE_NONE;
         cls_q    <= '0;
         funct3_q <= 3'd0;
         f7b5_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         cause_q  <= cause_d;
         cls_q    <= cls_d;
         funct3_q <= funct3_d;
         f7b5_q   <= f7b5_d;
      end
   end

   assign mem.mem_req  = mem_req;
   assign mem.mem_we   = mem_we;
   assign mem.addr_src = addr_src;
   assign ir_write_o   = ir_write;
   assign pc_write_o   = pc_write;
   assign pc_src_o     = pc_src;
   assign reg_write_o  = reg_write;
   assign result_src_o = result_src;
   assign alu_src_a_o  = alu_src_a;
   assign alu_src_b_o  = alu_src_b;
   assign imm_src_o    = imm_src;
   assign alu_op_o     = alu_op;
   assign halted_o     = (state_q == S_TRAP);
   assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
   import ripple_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        branch_taken;
   logic        ir_write, pc_write, pc_src, reg_write;
   logic [1:0]  result_src, alu_src_a;
   logic        alu_src_b;
   logic [2:0]  imm_src;
   logic [3:0]  alu_op;
   logic        halted;
   logic [1:0]  trap_cause;

   multicycle_control_fsm_if mem_bus();

   multicycle_control_fsm #(.MEM_TIMEOUT(4), .SUPPORT_SYSTEM(1'b1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem            (mem_bus),
      .instr_i        (instr),
      .branch_taken_i (branch_taken),
      .ir_write_o     (ir_write),
      .pc_write_o     (pc_write),
      .pc_src_o       (pc_src),
      .reg_write_o    (reg_write),
      .result_src_o   (result_src),
      .alu_src_a_o    (alu_src_a),
      .alu_src_b_o    (alu_src_b),
      .imm_src_o      (imm_src),
      .alu_op_o       (alu_op),
      .halted_o       (halted),
      .trap_cause_o   (trap_cause)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_src;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic       alu_src_b;
      logic [2:0] imm_src;
      logic [3:0] alu_op;
      logic       halted;
      logic [1:0] trap_cause;
   } outs_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        bt;
      outs_t       exp;
   } vec_t;

   vec_t  vecs[$];
   string vnames[$];
   int    passed = 0;
   int    total  = 0;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h40315093;
   localparam logic [31:0] I_ADDI  = 32'hC0000093;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_LUI   = 32'h123452B7;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_BADSH = 32'h02009093;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   function automatic outs_t mk(input logic req, input logic we, input logic asrc,
                                input logic irw, input logic pcw, input logic pcs,
                                input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                input logic sb, input logic [2:0] imm, input logic [3:0] op);
      outs_t o;
      o.mem_req    = req;
      o.mem_we     = we;
      o.addr_src   = asrc;
      o.ir_write   = irw;
      o.pc_write   = pcw;
      o.pc_src     = pcs;
      o.reg_write  = rw;
      o.result_src = rs;
      o.alu_src_a  = sa;
      o.alu_src_b  = sb;
      o.imm_src    = imm;
      o.alu_op     = op;
      o.halted     = 1'b0;
      o.trap_cause = 2'd0;
      return o;
   endfunction

   function automatic outs_t mk_trap(input logic [1:0] c);
      outs_t o;
      o            = '0;
      o.halted     = 1'b1;
      o.trap_cause = c;
      return o;
   endfunction

   function automatic outs_t cur();
      outs_t o;
      o.mem_req    = mem_bus.mem_req;
      o.mem_we     = mem_bus.mem_we;
      o.addr_src   = mem_bus.addr_src;
      o.ir_write   = ir_write;
      o.pc_write   = pc_write;
      o.pc_src     = pc_src;
      o.reg_write  = reg_write;
      o.result_src = result_src;
      o.alu_src_a  = alu_src_a;
      o.alu_src_b  = alu_src_b;
      o.imm_src    = imm_src;
      o.alu_op     = alu_op;
      o.halted     = halted;
      o.trap_cause = trap_cause;
      return o;
   endfunction

   function automatic void add(input string n, input logic [31:0] i, input logic r,
                               input logic b, input outs_t e);
      vec_t v;
      v.instr = i;
      v.rdy   = r;
      v.bt    = b;
      v.exp   = e;
      vecs.push_back(v);
      vnames.push_back(n);
   endfunction

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act = cur();
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   // Drive one cycle's inputs just after the rising edge, compare mid-cycle.
   task automatic step(input logic [31:0] i, input logic r, input logic b,
                       input string n, input outs_t e);
      instr             = i;
      mem_bus.mem_ready = r;
      branch_taken      = b;
      @(negedge clk);
      check(n, e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n             = 1'b0;
      instr             = 32'h0;
      mem_bus.mem_ready = 1'b0;
      branch_taken      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   outs_t z, fg, fw, wb_alu, wb_mem, wb_pc4;

   initial begin
      z      = mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);
      fg     = mk(1,0,0,1,1,0,0, RES_ALU, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);
      fw     = mk(1,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);
      wb_alu = mk(0,0,0,0,0,0,1, RES_ALU, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);
      wb_mem = mk(0,0,0,0,0,0,1, RES_MEM, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);
      wb_pc4 = mk(0,0,0,0,0,0,1, RES_PC4, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_ADD);

      // ADD x3,x1,x2: 4 cycles, reg_write only in cycle 4
      add("add_f",  I_ADD, 1, 0, fg);
      add("add_d",  I_ADD, 1, 0, z);
      add("add_e",  I_ADD, 1, 0, z);
      add("add_wb", I_ADD, 1, 0, wb_alu);
      // SUB
      add("sub_f",  I_SUB, 1, 0, fg);
      add("sub_d",  I_SUB, 1, 0, z);
      add("sub_e",  I_SUB, 1, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_RS2, IMM_I, ALU_SUB));
      add("sub_wb", I_SUB, 1, 0, wb_alu);
      // SRAI honours funct7b5
      add("srai_f",  I_SRAI, 1, 0, fg);
      add("srai_d",  I_SRAI, 1, 0, z);
      add("srai_e",  I_SRAI, 1, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_SRA));
      add("srai_wb", I_SRAI, 1, 0, wb_alu);
      // ADDI with bit30 set stays ADD
      add("addi_f",  I_ADDI, 1, 0, fg);
      add("addi_d",  I_ADDI, 1, 0, z);
      add("addi_e",  I_ADDI, 1, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_ADD));
      add("addi_wb", I_ADDI, 1, 0, wb_alu);
      // LW with 2 wait cycles in MEM: 7 cycles
      add("lw_f",   I_LW, 1, 0, fg);
      add("lw_d",   I_LW, 1, 0, z);
      add("lw_e",   I_LW, 0, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_ADD));
      add("lw_m0",  I_LW, 0, 0, mk(1,0,1,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_ADD));
      add("lw_m1",  I_LW, 0, 0, mk(1,0,1,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_ADD));
      add("lw_m2",  I_LW, 1, 0, mk(1,0,1,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_I, ALU_ADD));
      add("lw_wb",  I_LW, 1, 0, wb_mem);
      // SW: 4 cycles
      add("sw_f",  I_SW, 1, 0, fg);
      add("sw_d",  I_SW, 1, 0, z);
      add("sw_e",  I_SW, 1, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_S, ALU_ADD));
      add("sw_m",  I_SW, 1, 0, mk(1,1,1,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_S, ALU_ADD));
      // BEQ not taken, then taken: 3 cycles each
      add("beqn_f", I_BEQ, 1, 0, fg);
      add("beqn_d", I_BEQ, 1, 0, z);
      add("beqn_e", I_BEQ, 1, 0, mk(0,0,0,0,0,1,0, RES_ALU, SRC_A_PC, SRC_B_IMM, IMM_B, ALU_ADD));
      add("beqt_f", I_BEQ, 1, 1, fg);
      add("beqt_d", I_BEQ, 1, 1, z);
      add("beqt_e", I_BEQ, 1, 1, mk(0,0,0,0,1,1,0, RES_ALU, SRC_A_PC, SRC_B_IMM, IMM_B, ALU_ADD));
      // JAL
      add("jal_f",  I_JAL, 1, 0, fg);
      add("jal_d",  I_JAL, 1, 0, z);
      add("jal_e",  I_JAL, 1, 0, mk(0,0,0,0,1,1,0, RES_ALU, SRC_A_PC, SRC_B_IMM, IMM_J, ALU_ADD));
      add("jal_wb", I_JAL, 1, 0, wb_pc4);
      // LUI with one fetch wait cycle
      add("lui_fw", I_LUI, 0, 0, fw);
      add("lui_f",  I_LUI, 1, 0, fg);
      add("lui_d",  I_LUI, 1, 0, z);
      add("lui_e",  I_LUI, 1, 0, mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_ZERO, SRC_B_IMM, IMM_U, ALU_ADD));
      add("lui_wb", I_LUI, 1, 0, wb_alu);
      add("next_f", I_ADD, 1, 0, fg);

      // Reset state: everything low, even with mem_ready high
      rst_n             = 1'b0;
      instr             = I_ADD;
      mem_bus.mem_ready = 1'b1;
      branch_taken      = 1'b0;
      @(negedge clk);
      check("reset", z);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].instr, vecs[k].rdy, vecs[k].bt, vnames[k], vecs[k].exp);
      end

      // Illegal opcode: trap from the cycle after DECODE, held 100 cycles
      do_reset();
      step(I_ILL, 1, 0, "ill_f", fg);
      step(I_ILL, 1, 0, "ill_d", z);
      for (int k = 0; k < 100; k++) begin
         step(I_ILL, 1, 1, "ill_hold", mk_trap(CAUSE_ILLEGAL));
      end

      // ECALL traps with cause 2
      do_reset();
      step(I_ECALL, 1, 0, "ecall_f", fg);
      step(I_ECALL, 1, 0, "ecall_d", z);
      step(I_ECALL, 1, 0, "ecall_t0", mk_trap(CAUSE_ECALL));
      step(I_ECALL, 1, 0, "ecall_t1", mk_trap(CAUSE_ECALL));

      // Shift-immediate with funct7=0x01 is illegal
      do_reset();
      step(I_BADSH, 1, 0, "badsh_f", fg);
      step(I_BADSH, 1, 0, "badsh_d", z);
      step(I_BADSH, 1, 0, "badsh_t", mk_trap(CAUSE_ILLEGAL));

      // Fetch timeout: four wait cycles, then trap with cause 3 and no request
      do_reset();
      for (int k = 0; k < 4; k++) step(I_ADD, 0, 0, "to_wait", fw);
      step(I_ADD, 1, 0, "to_trap0", mk_trap(CAUSE_TIMEOUT));
      step(I_ADD, 1, 0, "to_trap1", mk_trap(CAUSE_TIMEOUT));

      // mem_ready on the last allowed wait cycle still succeeds
      do_reset();
      for (int k = 0; k < 3; k++) step(I_ADD, 0, 0, "edge_wait", fw);
      step(I_ADD, 1, 0, "edge_go",  fg);
      step(I_ADD, 1, 0, "edge_dec", z);
      step(I_ADD, 1, 0, "edge_ex",  z);
      step(I_ADD, 1, 0, "edge_wb",  wb_alu);

      // Reset mid-MEM store aborts the request immediately, then refetches
      do_reset();
      step(I_SW, 1, 0, "abort_f", fg);
      step(I_SW, 1, 0, "abort_d", z);
      step(I_SW, 0, 0, "abort_e", mk(0,0,0,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_S, ALU_ADD));
      instr             = I_SW;
      mem_bus.mem_ready = 1'b0;
      @(negedge clk);
      check("abort_mem", mk(1,1,1,0,0,0,0, RES_ALU, SRC_A_RS1, SRC_B_IMM, IMM_S, ALU_ADD));
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_drop", z);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(I_SW, 0, 0, "abort_refetch", fw);
      step(I_SW, 1, 0, "abort_fetch_go", fg);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
